// File: rtl/v74x139_rr_arb_pkg.sv
// Shared definitions for the '139-style round-robin arbiter: state encoding,
// requester count and the rotating-priority search.
package v74x139_rr_arb_pkg;

  localparam int REQ_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RECOVER = 2'b10
  } arb_state_t;

  // Returns {found, winner}. Search order is last+1, last+2, last+3, last;
  // walking the offsets downwards lets the earliest match overwrite later ones.
  function automatic logic [2:0] rr_pick(input logic [1:0] last,
                                         input logic [REQ_N-1:0] req_l);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = REQ_N; k >= 1; k--) begin
      idx = last + 2'(k);
      if (!req_l[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

endpackage

// File: rtl/v74x139_rr_arb_dec2to4.sv
// Combinational 2-to-4 decoder with active-low enable and active-low outputs,
// the function of one half of a 74x139.
module v74x139_rr_arb_dec2to4 (
  input  logic       en_l,
  input  logic [1:0] a,
  output logic [3:0] y_l
);

  always_comb begin
    y_l = 4'b1111;
    if (!en_l) y_l[a] = 1'b0;
  end

endmodule

// File: rtl/v74x139_rr_arb.sv
// Four-requester round-robin bus arbiter: registered active-low grants,
// bounded tenures and one dead cycle between consecutive owners.
module v74x139_rr_arb
  import v74x139_rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REQ_N-1:0] req_l,
  input  logic             done,
  output logic [REQ_N-1:0] gnt_l,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  // Handshake: a requester holds req_l[i] low as a level until it is served;
  // the owner ends its tenure by raising req_l[sel] or pulsing done for one
  // cycle. done is only meaningful while busy=1.
  arb_state_t       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             timeout_d;
  logic [2:0]       pick;
  logic             withdrawn, expired;
  logic [REQ_N-1:0] gnt_l_d;

  always_comb begin
    pick      = rr_pick(last_q, req_l);
    withdrawn = req_l[sel];
    expired   = (cnt_q == HOLD_LAST);
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick[2]) begin
          state_d = ST_GRANT;
          sel_d   = pick[1:0];
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (withdrawn || done || expired) begin
          state_d   = ST_RECOVER;
          last_d    = sel;
          timeout_d = expired && !withdrawn && !done;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        // last_q already holds the owner that just left, so it loses priority.
        if (pick[2]) begin
          state_d = ST_GRANT;
          sel_d   = pick[1:0];
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decode from next-state so the grant register changes only on a clock edge.
  v74x139_rr_arb_dec2to4 u_dec (
    .en_l (state_d != ST_GRANT),
    .a    (sel_d),
    .y_l  (gnt_l_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 2'b11;
      sel     <= 2'b00;
      cnt_q   <= '0;
      gnt_l   <= 4'b1111;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel     <= sel_d;
      cnt_q   <= cnt_d;
      gnt_l   <= gnt_l_d;
      busy    <= (state_d == ST_GRANT);
      timeout <= timeout_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_v74x139_rr_arb.sv
// Directed bench for the round-robin arbiter: timeout tenure, rotation,
// withdrawal, done-at-expiry and asynchronous reset mid-tenure.
module tb_v74x139_rr_arb;

  logic       clk;
  logic       reset_n;
  logic [3:0] req_l;
  logic       done;
  logic [3:0] gnt_l;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
  logic [1:0] state_dbg;

  int  n_checks = 0;
  int  n_err    = 0;
  bit  mon_en   = 0;
  time last_edge_t = 0;

  logic [1:0] exp_q[$];

  v74x139_rr_arb #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_l     (req_l),
    .done      (done),
    .gnt_l     (gnt_l),
    .sel       (sel),
    .busy      (busy),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) last_edge_t = $time;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Grant lines: at most one low, and only changing on a clock or reset edge.
  always @(gnt_l) begin
    if (mon_en) begin
      chk("gnt_onehot", 8'($onehot0(~gnt_l)), 8'd1);
      chk("gnt_edge", 8'(last_edge_t == $time), 8'd1);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req_l   = 4'b1111;
    done    = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] onecold(input logic [1:0] i);
    logic [3:0] g;
    g = 4'b1111;
    g[i] = 1'b0;
    return g;
  endfunction

  initial begin
    logic [1:0] e;
    reset_n = 1'b0;
    req_l   = 4'b1111;
    done    = 1'b0;
    step();
    step();
    chk("rst_gnt", 8'(gnt_l), 8'h0f);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_timeout", 8'(timeout), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_state", 8'(state_dbg), 8'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Timeout tenure: requester 0 alone for MAX_HOLD cycles
    step();
    req_l = 4'b1110;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_gnt", 8'(gnt_l), 8'h0e);
      chk("t1_sel", 8'(sel), 8'd0);
      chk("t1_busy", 8'(busy), 8'd1);
      chk("t1_to_low", 8'(timeout), 8'd0);
    end
    step();
    chk("t1_rec_gnt", 8'(gnt_l), 8'h0f);
    chk("t1_rec_to", 8'(timeout), 8'd1);
    chk("t1_rec_busy", 8'(busy), 8'd0);
    step();
    chk("t1_regrant", 8'(gnt_l), 8'h0e);
    chk("t1_regrant_to", 8'(timeout), 8'd0);
    req_l = 4'b1111;
    step();
    chk("t1_wd_to", 8'(timeout), 8'd0);
    step();
    chk("t1_idle", 8'(state_dbg), 8'd0);

    // Rotation with all requesting, done on each owner's 2nd cycle
    do_reset();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req_l = 4'b0000;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      chk("t2_sel", 8'(sel), 8'(e));
      chk("t2_gnt1", 8'(gnt_l), 8'(onecold(e)));
      step();
      chk("t2_gnt2", 8'(gnt_l), 8'(onecold(e)));
      done = 1'b1;
      step();
      done = 1'b0;
      chk("t2_gap", 8'(gnt_l), 8'h0f);
      chk("t2_gap_busy", 8'(busy), 8'd0);
      chk("t2_to", 8'(timeout), 8'd0);
      if (exp_q.size() == 0) req_l = 4'b1111;
    end
    step();
    chk("t2_idle", 8'(state_dbg), 8'd0);

    // Withdrawal: requester 2 leaves, requester 1 next (order 3,0,1,2)
    req_l = 4'b1011;
    step();
    chk("t3_gnt2", 8'(gnt_l), 8'h0b);
    req_l = 4'b1001;
    step();
    chk("t3_hold2", 8'(gnt_l), 8'h0b);
    step();
    chk("t3_hold3", 8'(gnt_l), 8'h0b);
    req_l = 4'b1101;
    step();
    chk("t3_gap", 8'(gnt_l), 8'h0f);
    chk("t3_gap_to", 8'(timeout), 8'd0);
    step();
    chk("t3_gnt1", 8'(gnt_l), 8'h0d);
    chk("t3_sel1", 8'(sel), 8'd1);

    // done coincident with the last hold cycle: no TIMEOUT
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_hold", 8'(gnt_l), 8'h0d);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t4_gap", 8'(gnt_l), 8'h0f);
    chk("t4_to", 8'(timeout), 8'd0);
    chk("t4_state", 8'(state_dbg), 8'd2);
    step();
    chk("t4_regrant", 8'(gnt_l), 8'h0d);

    // Async reset mid-tenure of requester 2
    req_l = 4'b1011;
    step();
    chk("t5_gap", 8'(gnt_l), 8'h0f);
    step();
    chk("t5_gnt2", 8'(gnt_l), 8'h0b);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_gnt", 8'(gnt_l), 8'h0f);
    chk("t5_async_busy", 8'(busy), 8'd0);
    chk("t5_async_state", 8'(state_dbg), 8'd0);
    step();
    reset_n = 1'b1;
    step();
    chk("t5_post_gnt", 8'(gnt_l), 8'h0b);
    chk("t5_post_sel", 8'(sel), 8'd2);
    req_l = 4'b1111;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
